// File: rtl/wb_uart_tx_slave.sv
// Wishbone classic slave with DATA/STATUS/DIV registers feeding a TX FIFO
// that is drained as 8N1 frames on tx_o.
module wb_uart_tx_slave #(
  parameter int          ADDR_WIDTH  = 24,
  parameter int          DATA_WIDTH  = 32,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  input  logic                  wb_cyc_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_rty_o,
  output logic                  tx_o,
  output logic                  irq_o,
  output logic [1:0]            dbg_state_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // S_IDLE is encoded as 0 so dbg_state_o != 0 means busy.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3} tx_state_t;

  tx_state_t         state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_d;
  logic [15:0]       div_q;
  logic [15:0]       period_m1;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    level;
  logic              full, empty, push, pop;

  logic              req, div_we;
  logic              ack_d, err_d, rty_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [31:0]       status;
  logic              unused_ok;

  assign full      = (level == (PTR_W+1)'(FIFO_DEPTH));
  assign empty     = (level == '0);
  assign period_m1 = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
  assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o & ~wb_rty_o;
  assign unused_ok = ^{wb_addr_i[ADDR_WIDTH-1:4], wb_addr_i[1:0], wb_sel_i[3:2],
                       wb_data_i[DATA_WIDTH-1:16]};
  assign dbg_state_o = state_q;

  always_comb begin
    status      = '0;
    status[0]   = (state_q != S_IDLE);
    status[1]   = full;
    status[2]   = empty;
    status[15:8] = 8'(level);
  end

  // Bus decode: full is judged on the pre-pop level, so a same-cycle pop still retries.
  always_comb begin
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rty_d   = 1'b0;
    rdata_d = '0;
    push    = 1'b0;
    div_we  = 1'b0;
    if (req) begin
      unique case (wb_addr_i[3:2])
        2'd0: begin
          if (wb_we_i && wb_sel_i[0] && full) begin
            rty_d = 1'b1;
          end else begin
            ack_d = 1'b1;
            push  = wb_we_i & wb_sel_i[0];
          end
        end
        2'd1: begin
          ack_d = 1'b1;
          if (!wb_we_i) rdata_d = DATA_WIDTH'(status);
        end
        2'd2: begin
          ack_d  = 1'b1;
          div_we = wb_we_i;
          if (!wb_we_i) rdata_d = DATA_WIDTH'({16'b0, div_q});
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_o;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          cnt_d   = period_m1;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == 16'd0) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          cnt_d   = period_m1;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = period_m1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == 16'd0) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            cnt_d   = period_m1;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      tx_o      <= 1'b1;
      irq_o     <= 1'b0;
      div_q     <= DEFAULT_DIV;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      wb_ack_o  <= 1'b0;
      wb_err_o  <= 1'b0;
      wb_rty_o  <= 1'b0;
      wb_data_o <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tx_o      <= tx_d;
      irq_o     <= empty & (state_q == S_IDLE);
      wb_ack_o  <= ack_d;
      wb_err_o  <= err_d;
      wb_rty_o  <= rty_d;
      wb_data_o <= rdata_d;
      if (div_we && wb_sel_i[0]) div_q[7:0]  <= wb_data_i[7:0];
      if (div_we && wb_sel_i[1]) div_q[15:8] <= wb_data_i[15:8];
      if (push) begin
        mem[wr_ptr] <= wb_data_i[7:0];
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      level <= level + (PTR_W+1)'(1);
      else if (pop && !push) level <= level - (PTR_W+1)'(1);
    end
  end

endmodule

// File: tb/tb_wb_uart_tx_slave.sv
// Bench for wb_uart_tx_slave: frame-timeline reference model checked every cycle,
// directed scenarios pinned with literal values, then randomized bus traffic.
module tb_wb_uart_tx_slave;

  localparam int          DEPTH = 8;
  localparam logic [15:0] DEF_DIV = 16'd434;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [23:0] wb_addr_i = '0;
  logic [31:0] wb_data_i = '0;
  logic [31:0] wb_data_o;
  logic        wb_cyc_i = 1'b0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic        wb_ack_o, wb_err_o, wb_rty_o, tx_o, irq_o;
  logic [1:0]  dbg_state_o;

  int n_cmp = 0;
  int n_fail = 0;

  wb_uart_tx_slave #(.ADDR_WIDTH(24), .DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(DEF_DIV)) dut (
    .clk_i(clk), .rst_i(rst_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .wb_data_o(wb_data_o), .wb_cyc_i(wb_cyc_i), .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i),
    .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
    .tx_o(tx_o), .irq_o(irq_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset(input int cycles);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    rst_i = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO is a queue, a frame is a 10-bit vector played out
  // from its start cycle, one bit per P cycles.
  logic [7:0]  exp_q[$];
  bit          m_live = 0;
  logic        m_ack, m_err, m_rty, m_busy, m_tx, m_irq;
  logic [31:0] m_rdata;
  logic [15:0] m_div;
  logic [9:0]  m_frame;
  int          m_t0, m_p;
  int          cyc_n = 0;

  always @(posedge clk) begin : model
    int          pre_size;
    logic        pre_busy, req, do_push, n_ack, n_err, n_rty;
    logic [31:0] n_data;
    logic [15:0] new_div;
    logic [7:0]  b;
    if (rst_i) begin
      m_live = 1; m_ack = 0; m_err = 0; m_rty = 0; m_rdata = 0;
      m_div = DEF_DIV; exp_q.delete(); m_busy = 0; m_tx = 1; m_irq = 0;
    end else begin
      pre_size = exp_q.size();
      pre_busy = m_busy;
      req = wb_cyc_i & wb_stb_i & ~m_ack & ~m_err & ~m_rty;
      n_ack = 0; n_err = 0; n_rty = 0; n_data = 0; do_push = 0; new_div = m_div;
      if (req) begin
        case (wb_addr_i[3:2])
          2'd0: begin
            if (wb_we_i && wb_sel_i[0] && pre_size == DEPTH) n_rty = 1;
            else begin n_ack = 1; do_push = wb_we_i & wb_sel_i[0]; end
          end
          2'd1: begin
            n_ack = 1;
            if (!wb_we_i) n_data = {16'b0, 8'(pre_size), 5'b0, pre_size == 0, pre_size == DEPTH, pre_busy};
          end
          2'd2: begin
            n_ack = 1;
            if (!wb_we_i) n_data = {16'b0, m_div};
            else begin
              if (wb_sel_i[0]) new_div[7:0]  = wb_data_i[7:0];
              if (wb_sel_i[1]) new_div[15:8] = wb_data_i[15:8];
            end
          end
          default: n_err = 1;
        endcase
      end
      if (m_busy && (cyc_n - m_t0) == 10 * m_p) m_busy = 0;
      if (!m_busy && exp_q.size() > 0) begin
        b = exp_q.pop_front();
        m_frame = {1'b1, b, 1'b0};
        m_t0 = cyc_n;
        m_p = (m_div == 0) ? 1 : int'(m_div);
        m_busy = 1;
      end
      if (do_push) exp_q.push_back(wb_data_i[7:0]);
      m_tx = m_busy ? m_frame[(cyc_n - m_t0) / m_p] : 1'b1;
      m_irq = !pre_busy && pre_size == 0;
      m_ack = n_ack; m_err = n_err; m_rty = n_rty; m_rdata = n_data;
      m_div = new_div;
    end
    cyc_n++;
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("ack", wb_ack_o, m_ack);
      check("err", wb_err_o, m_err);
      check("rty", wb_rty_o, m_rty);
      check("rdata", wb_data_o, m_rdata);
      check("tx", tx_o, m_tx);
      check("irq", irq_o, m_irq);
      check("busy", dbg_state_o != 2'd0, m_busy);
    end
  end

  // ---------------- driver ----------------
  // Handshake: a request is cyc&stb held until exactly one of ack/err/rty is
  // seen for a cycle; the master then drops or replaces the request.
  task automatic xfer(input logic we, input logic [23:0] addr, input logic [31:0] data,
                      input logic [3:0] sel, output int kind, output logic [31:0] rd);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_addr_i = addr; wb_data_i = data; wb_sel_i = sel;
    kind = 0; rd = '0;
    for (int i = 0; i < 8 && kind == 0; i++) begin
      @(negedge clk);
      if (wb_ack_o) kind = 1;
      else if (wb_err_o) kind = 2;
      else if (wb_rty_o) kind = 3;
      rd = wb_data_o;
    end
    check("xfer_terminated", kind != 0, 1'b1);
    @(posedge clk);
    #1 wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          k, k2;
    logic [31:0] r, r2;
    logic [63:0] txv, irqv, expv;
    logic [9:0]  f0, f1, fa5;
    int          acks;
    int          kinds[10];
    int          zeros;

    do_reset(3);
    @(negedge clk) check("irq_first_cycle", irq_o, 1'b0);
    @(negedge clk) check("irq_second_cycle", irq_o, 1'b1);
    check("tx_idle", tx_o, 1'b1);
    sync();
    xfer(0, 24'h000004, 0, 4'hF, k, r); check("status_reset", r, 32'h00000004);
    xfer(0, 24'h000008, 0, 4'hF, k, r); check("div_reset", r, 32'h000001B2);

    // Single 0xA5 frame at DIV=4
    fa5 = 10'b1101001010;
    xfer(1, 24'h000008, 32'd4, 4'h3, k, r);
    xfer(1, 24'h000000, 32'hA5, 4'h1, k, r);
    check("a5_push_ack", k, 1);
    txv = '0; expv = '0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          txv[i] = tx_o;
          expv[i] = fa5[i / 4];
          if (i == 20) check("irq_mid_frame", irq_o, 1'b0);
        end
      end
      begin
        repeat (10) @(negedge clk);
        sync();
        xfer(0, 24'h000004, 0, 4'hF, k2, r2);
        check("status_busy", r2, 32'h00000005);
      end
    join
    check("a5_waveform", txv, expv);
    @(negedge clk);
    @(negedge clk) check("irq_after_frame", irq_o, 1'b1);

    // Fill the FIFO behind a slow frame
    sync();
    xfer(1, 24'h000008, 32'd1000, 4'h3, k, r);
    for (int i = 0; i < 10; i++) xfer(1, 24'h000000, 32'h40 + i, 4'h1, kinds[i], r);
    acks = 0;
    for (int i = 0; i < 9; i++) if (kinds[i] == 1) acks++;
    check("burst_acks", acks, 9);
    check("burst_10th_rty", kinds[9], 3);
    xfer(0, 24'h000004, 0, 4'hF, k, r); check("status_full", r, 32'h00000803);
    do_reset(2);

    // Unmapped offset and byte-lane DIV write
    sync();
    xfer(0, 24'hFF000C, 0, 4'hF, k, r); check("err_read_kind", k, 2); check("err_read_data", r, 0);
    xfer(1, 24'h00000F, 32'hDEADBEEF, 4'hF, k, r); check("err_write_kind", k, 2);
    xfer(1, 24'h000008, 32'd4, 4'h3, k, r);
    xfer(1, 24'h000008, 32'h12345678, 4'b0010, k, r);
    xfer(0, 24'hA5A50A, 0, 4'hF, k, r); check("div_lane_write", r, 32'h00005604);

    // Back-to-back frames at DIV=2: no gap between stop and next start
    xfer(1, 24'h000008, 32'd2, 4'h3, k, r);
    f0 = 10'b1000000000;
    f1 = 10'b1111111110;
    txv = '0; irqv = '0; expv = '0;
    fork
      begin
        for (int i = 0; i < 42; i++) begin
          @(negedge clk);
          txv[i] = tx_o;
          irqv[i] = irq_o;
          if (i < 2) expv[i] = 1'b1;
          else if (i < 22) expv[i] = f0[(i - 2) / 2];
          else expv[i] = f1[(i - 22) / 2];
        end
      end
      begin
        xfer(1, 24'h000000, 32'h00, 4'h1, k, r);
        xfer(1, 24'h000000, 32'hFF, 4'h1, k2, r2);
      end
    join
    check("b2b_waveform", txv, expv);
    check("b2b_irq_low", irqv[41:2], 40'd0);
    @(negedge clk);
    @(negedge clk) check("b2b_irq_after", irq_o, 1'b1);

    // Reset during data bit 3, with a second byte queued
    sync();
    xfer(1, 24'h000008, 32'd4, 4'h3, k, r);
    xfer(1, 24'h000000, 32'hA5, 4'h1, k, r);
    xfer(1, 24'h000000, 32'h3C, 4'h1, k, r);
    repeat (15) @(posedge clk);
    #1;
    @(negedge clk) check("tx_data_bit3", tx_o, 1'b0);
    rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk) check("tx_after_reset", tx_o, 1'b1);
    sync();
    xfer(0, 24'h000004, 0, 4'hF, k, r); check("status_after_reset", r, 32'h00000004);
    xfer(0, 24'h000008, 0, 4'hF, k, r); check("div_after_reset", r, 32'h000001B2);
    zeros = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_o !== 1'b1) zeros++;
    end
    check("no_frame_after_reset", zeros, 0);

    // Randomized traffic; DIV only changes while the transmitter is drained
    for (int round = 0; round < 5; round++) begin
      sync();
      xfer(1, 24'($urandom), 32'($urandom_range(0, 5)), 4'h3, k, r);
      wb_addr_i[3:2] = 2'd2;
      for (int t = 0; t < 30; t++) begin
        logic [23:0] a;
        logic        we;
        int          gap;
        a = 24'($urandom);
        if ($urandom_range(0, 2) != 0) a[3:2] = 2'd0;
        we = 1'($urandom);
        if (a[3:2] == 2'd2) we = 1'b0;
        xfer(we, a, $urandom, 4'($urandom), k, r);
        gap = $urandom_range(0, 3);
        if (gap > 0) begin
          repeat (gap) @(posedge clk);
          #1;
        end
      end
      for (int i = 0; i < 4000 && (m_busy || exp_q.size() != 0); i++) @(posedge clk);
      check("drained", m_busy || exp_q.size() != 0, 1'b0);
      repeat (3) @(posedge clk);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
